// File: rtl/requant_pkg.sv
// Shared constants, saturation-limit helpers and the stage-1 lane record for the requantiser.
package requant_pkg;

    localparam int unsigned IN_W_DEF    = 32;
    localparam int unsigned OUT_W_DEF   = 16;
    localparam int unsigned SHIFT_W_DEF = 5;

    // Stage-1 truncated values are held sign-extended to this width so one record type fits any IN_W.
    localparam int unsigned IN_W_MAX = 64;
    localparam int unsigned ACC_W    = IN_W_MAX + 1;

    function automatic logic signed [ACC_W-1:0] sat_max(input int unsigned w);
        logic [ACC_W-1:0] v;
        v = (ACC_W'(1) << (w - 1)) - ACC_W'(1);
        return $signed(v);
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_min(input int unsigned w);
        logic [ACC_W-1:0] v;
        v = ~((ACC_W'(1) << (w - 1)) - ACC_W'(1));
        return $signed(v);
    endfunction

    localparam logic signed [ACC_W-1:0] OUT_MAX = sat_max(OUT_W_DEF);
    localparam logic signed [ACC_W-1:0] OUT_MIN = sat_min(OUT_W_DEF);

    typedef struct packed {
        logic [IN_W_MAX-1:0] trunc;
        logic                r;
        logic                s;
        logic                l;
    } s1_rec_t;

endpackage

// File: rtl/requant_lane.sv
// One requantiser lane: S1 floor-shift with guard/sticky/lsb capture, S2 round-half-even and saturate.
// REQ_RELU_EN: when defined, negative rounded results are forced to zero before saturation.
module requant_lane
    import requant_pkg::*;
#(
    parameter int unsigned IN_W    = IN_W_DEF,
    parameter int unsigned OUT_W   = OUT_W_DEF,
    parameter int unsigned SHIFT_W = SHIFT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic [IN_W-1:0]    i_din,
    input  logic [SHIFT_W-1:0] i_shift,
    output logic [OUT_W-1:0]   o_dout,
    output logic               o_sat
);

    localparam int unsigned SH_CW = (IN_W > 1) ? $clog2(IN_W) : 1;

    localparam logic signed [ACC_W-1:0] LANE_MAX = (OUT_W == OUT_W_DEF) ? OUT_MAX : sat_max(OUT_W);
    localparam logic signed [ACC_W-1:0] LANE_MIN = (OUT_W == OUT_W_DEF) ? OUT_MIN : sat_min(OUT_W);

    logic [SH_CW-1:0]           w_s;
    logic signed [IN_W_MAX-1:0] w_ext;
    logic signed [IN_W_MAX-1:0] w_trunc;
    logic                       w_r;
    logic                       w_st;
    logic                       w_inc;
    logic signed [ACC_W-1:0]    w_sum;
    logic signed [ACC_W-1:0]    w_pre;
    logic [OUT_W-1:0]           w_res;
    logic                       w_sat;

    s1_rec_t                    r_s1;
    logic [OUT_W-1:0]           r_dout;
    logic                       r_sat;

    // Shifts beyond the word width behave as a shift by IN_W-1.
    always_comb begin
        w_s = SH_CW'(IN_W - 1);
        if (32'(i_shift) < IN_W) begin
            w_s = SH_CW'(i_shift);
        end
    end

    assign w_ext   = IN_W_MAX'($signed(i_din));
    assign w_trunc = w_ext >>> w_s;

    // Guard is the bit just below the cut; sticky ORs everything below the guard.
    always_comb begin
        w_r  = 1'b0;
        w_st = 1'b0;
        for (int k = 0; k < int'(IN_W); k++) begin
            if (k + 1 == int'(w_s)) begin
                w_r = i_din[k];
            end
            if (k + 2 <= int'(w_s)) begin
                w_st = w_st | i_din[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
        end else if (i_en) begin
            r_s1.trunc <= w_trunc;
            r_s1.r     <= w_r;
            r_s1.s     <= w_st;
            r_s1.l     <= w_trunc[0];
        end
    end

    assign w_inc = r_s1.r & (r_s1.s | r_s1.l);
    assign w_sum = $signed({r_s1.trunc[IN_W_MAX-1], r_s1.trunc})
                 + $signed({{(ACC_W-1){1'b0}}, w_inc});

`ifdef REQ_RELU_EN
    assign w_pre = w_sum[ACC_W-1] ? '0 : w_sum;
`else
    assign w_pre = w_sum;
`endif

    always_comb begin
        w_res = OUT_W'(w_pre);
        w_sat = 1'b0;
        if (w_pre > LANE_MAX) begin
            w_res = OUT_W'(LANE_MAX);
            w_sat = 1'b1;
        end else if (w_pre < LANE_MIN) begin
            w_res = OUT_W'(LANE_MIN);
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
            r_sat  <= 1'b0;
        end else if (i_en) begin
            r_dout <= w_res;
            r_sat  <= w_sat;
        end
    end

    assign o_dout = r_dout;
    assign o_sat  = r_sat;

endmodule

// File: rtl/requant_shift_round.sv
// Multi-lane requantiser top: stall-all two-stage pipeline, frame-last passthrough, saturation counter.
// REQ_RELU_EN (lane build option) selects unsigned ReLU output; the port list does not change.
module requant_shift_round
    import requant_pkg::*;
#(
    parameter int unsigned IN_W    = IN_W_DEF,
    parameter int unsigned OUT_W   = OUT_W_DEF,
    parameter int unsigned SHIFT_W = SHIFT_W_DEF,
    parameter int unsigned LANES   = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    input  logic [SHIFT_W-1:0]     in_shift,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic                   out_last,
    output logic [LANES-1:0]       out_sat,
    output logic [CNT_W-1:0]       sat_count,
    input  logic                   sat_clr
);

    logic             w_en;
    logic             w_sat_evt;
    logic             r_s1_valid;
    logic             r_s1_last;
    logic             r_out_valid;
    logic             r_out_last;
    logic [CNT_W-1:0] r_sat_count;

    // Whole pipeline advances together whenever the output slot is free or being drained.
    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_en) begin
            r_s1_valid  <= in_valid;
            r_s1_last   <= in_last;
            r_out_valid <= r_s1_valid;
            r_out_last  <= r_s1_last;
        end
    end

    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
        requant_lane #(
            .IN_W    (IN_W),
            .OUT_W   (OUT_W),
            .SHIFT_W (SHIFT_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_en    (w_en),
            .i_din   (in_data[g*IN_W +: IN_W]),
            .i_shift (in_shift),
            .o_dout  (out_data[g*OUT_W +: OUT_W]),
            .o_sat   (out_sat[g])
        );
    end

    // Count delivered beats with any clamped lane; clear wins over a same-cycle event.
    assign w_sat_evt = r_out_valid && out_ready && (|out_sat);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if (sat_clr) begin
            r_sat_count <= '0;
        end else if (w_sat_evt && (r_sat_count != '1)) begin
            r_sat_count <= r_sat_count + CNT_W'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign sat_count = r_sat_count;

endmodule
